// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver. Two-flop synchroniser, 3-sample
// majority vote, false-start rejection, optional parity, 1 or 2 stop bits,
// and per-frame parity/framing/break status that updates with the valid pulse.
module uart_rx_cfg #(
  parameter int unsigned CYCLES_PER_BIT = 5000,
  parameter int unsigned PAYLOAD_BITS   = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned PARITY_EN      = 0,
  parameter int unsigned PARITY_ODD     = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_perr,
  output logic                    uart_rx_ferr,
  output logic                    uart_rx_break,
  output logic                    uart_rx_busy
);

  localparam int unsigned      CNT_W    = $clog2(CYCLES_PER_BIT + 1);
  localparam int unsigned      BC_W     = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(CYCLES_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(PAYLOAD_BITS - 1);
  localparam logic             PODD     = (PARITY_ODD != 0);
  localparam logic             PAR_ON   = (PARITY_EN != 0);
  localparam logic             ONE_STOP = (STOP_BITS == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              sync_q;
  logic [2:0]              hist_q;
  logic                    maj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    perr_acc_q, perr_acc_d;
  logic                    ferr_acc_q, ferr_acc_d;
  logic                    ferr_now;
  logic                    valid_q, valid_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    brk_q, brk_d;

  // Input path: synchroniser (parked high while disabled) then sample history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= uart_rx_en ? {sync_q[0], uart_rxd} : 2'b11;
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  // State and frame registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  // Next-state logic: bit timing, sampling and end-of-frame status update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    ferr_now   = ferr_acc_q | ~maj;
    if (!uart_rx_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!sync_q[1]) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_C) begin
            cnt_d = '0;
            if (maj) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              bit_cnt_d  = '0;
              perr_acc_d = 1'b0;
              ferr_acc_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == LAST_C) begin
            cnt_d = '0;
            // Shifting in from the MSB lands the first (LSB) bit at bit 0
            // after PAYLOAD_BITS samples, same result as indexed stores.
            shift_d   = {maj, shift_q[PAYLOAD_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              stop_cnt_d = 1'b0;
              state_d    = PAR_ON ? S_PARITY : S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == LAST_C) begin
            cnt_d      = '0;
            perr_acc_d = (^shift_q) ^ maj ^ PODD;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == LAST_C) begin
            cnt_d      = '0;
            ferr_acc_d = ferr_now;
            if (ONE_STOP || stop_cnt_q) begin
              state_d = S_IDLE;
              valid_d = 1'b1;
              data_d  = shift_q;
              perr_d  = perr_acc_q;
              ferr_d  = ferr_now;
              brk_d   = ferr_now & (shift_q == '0);
            end else begin
              stop_cnt_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign uart_rx_valid = valid_q;
  assign uart_rx_data  = data_q;
  assign uart_rx_perr  = perr_q;
  assign uart_rx_ferr  = ferr_q;
  assign uart_rx_break = brk_q;
  assign uart_rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, even-parity and 5-bit/2-stop instances
// at 16 clocks per bit, with hand-computed expected frames and status.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rxd_a = 1'b1, rxd_p = 1'b1, rxd_s = 1'b1;
  logic en_a = 1'b1, en_o = 1'b1;

  logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
  logic [7:0] data_a;
  logic       valid_p, perr_p, ferr_p, brk_p, busy_p;
  logic [7:0] data_p;
  logic       valid_s, perr_s, ferr_s, brk_s, busy_s;
  logic [4:0] data_s;

  int checks = 0;
  int errors = 0;
  int nval_a = 0, nval_p = 0, nval_s = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CYCLES_PER_BIT(16), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .uart_rx_en(en_a),
    .uart_rx_valid(valid_a), .uart_rx_data(data_a), .uart_rx_perr(perr_a),
    .uart_rx_ferr(ferr_a), .uart_rx_break(brk_a), .uart_rx_busy(busy_a));

  uart_rx_cfg #(.CYCLES_PER_BIT(16), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_p), .uart_rx_en(en_o),
    .uart_rx_valid(valid_p), .uart_rx_data(data_p), .uart_rx_perr(perr_p),
    .uart_rx_ferr(ferr_p), .uart_rx_break(brk_p), .uart_rx_busy(busy_p));

  uart_rx_cfg #(.CYCLES_PER_BIT(16), .PAYLOAD_BITS(5), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_s (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_s), .uart_rx_en(en_o),
    .uart_rx_valid(valid_s), .uart_rx_data(data_s), .uart_rx_perr(perr_s),
    .uart_rx_ferr(ferr_s), .uart_rx_break(brk_s), .uart_rx_busy(busy_s));

  // Count valid pulses per instance, sampled away from the rising edge.
  always @(negedge clk) begin
    if (valid_a) nval_a = nval_a + 1;
    if (valid_p) nval_p = nval_p + 1;
    if (valid_s) nval_s = nval_s + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0:       rxd_a = v;
      1:       rxd_p = v;
      default: rxd_s = v;
    endcase
  endtask

  // Send frame[0..n-1] LSB first, 16 clocks per bit; optionally check u_a
  // busy at the middle of every bit.
  task automatic send(input int which, input logic [15:0] frame, input int n, input bit chk_busy);
    for (int i = 0; i < n; i++) begin
      drive(which, frame[i]);
      for (int c = 0; c < 16; c++) begin
        @(posedge clk);
        #1;
        if (chk_busy && c == 7) chk("busy_mid_bit", {31'b0, busy_a}, 32'd1);
      end
    end
  endtask

  initial begin
    // Reset state
    cycles(4);
    chk("rst_valid", {31'b0, valid_a}, 32'd0);
    chk("rst_data",  {24'b0, data_a},  32'd0);
    chk("rst_perr",  {31'b0, perr_a},  32'd0);
    chk("rst_ferr",  {31'b0, ferr_a},  32'd0);
    chk("rst_break", {31'b0, brk_a},   32'd0);
    chk("rst_busy",  {31'b0, busy_a},  32'd0);
    resetn = 1'b1;
    cycles(10);

    // 1: 8N1 back-to-back 0xA5, 0x3C
    send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b1);
    chk("t1_cnt0",  nval_a, 32'd1);
    chk("t1_data0", {24'b0, data_a}, 32'hA5);
    send(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b1);
    chk("t1_cnt1",  nval_a, 32'd2);
    chk("t1_data1", {24'b0, data_a}, 32'h3C);
    chk("t1_perr",  {31'b0, perr_a}, 32'd0);
    chk("t1_ferr",  {31'b0, ferr_a}, 32'd0);
    chk("t1_break", {31'b0, brk_a},  32'd0);
    cycles(20);
    chk("t1_idle_busy", {31'b0, busy_a}, 32'd0);

    // 2: even parity, good then bad parity bit
    send(1, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0);
    chk("t2_cnt0",  nval_p, 32'd1);
    chk("t2_perr0", {31'b0, perr_p}, 32'd0);
    chk("t2_data0", {24'b0, data_p}, 32'hA5);
    send(1, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0);
    chk("t2_cnt1",  nval_p, 32'd2);
    chk("t2_perr1", {31'b0, perr_p}, 32'd1);
    chk("t2_ferr1", {31'b0, ferr_p}, 32'd0);
    chk("t2_brk1",  {31'b0, brk_p},  32'd0);
    chk("t2_data1", {24'b0, data_p}, 32'hA5);
    cycles(20);

    // 3: break (0x00, stop 0) then 0x81 with stop 0
    send(0, {6'b0, 1'b0, 8'h00, 1'b0}, 10, 1'b0);
    rxd_a = 1'b1;
    chk("t3_cnt0",  nval_a, 32'd3);
    chk("t3_data0", {24'b0, data_a}, 32'h00);
    chk("t3_ferr0", {31'b0, ferr_a}, 32'd1);
    chk("t3_brk0",  {31'b0, brk_a},  32'd1);
    chk("t3_perr0", {31'b0, perr_a}, 32'd0);
    cycles(30);
    send(0, {6'b0, 1'b0, 8'h81, 1'b0}, 10, 1'b0);
    rxd_a = 1'b1;
    chk("t3_cnt1",  nval_a, 32'd4);
    chk("t3_data1", {24'b0, data_a}, 32'h81);
    chk("t3_ferr1", {31'b0, ferr_a}, 32'd1);
    chk("t3_brk1",  {31'b0, brk_a},  32'd0);
    cycles(30);
    chk("t3_no_extra", nval_a, 32'd4);

    // 4: glitches on idle line
    rxd_a = 1'b0;
    cycles(1);
    rxd_a = 1'b1;
    cycles(40);
    chk("t4_glitch1_cnt", nval_a, 32'd4);
    rxd_a = 1'b0;
    cycles(6);
    chk("t4_start_busy", {31'b0, busy_a}, 32'd1);
    rxd_a = 1'b1;
    cycles(10);
    chk("t4_false_busy", {31'b0, busy_a}, 32'd0);
    cycles(30);
    chk("t4_glitch6_cnt", nval_a, 32'd4);
    chk("t4_data_held",   {24'b0, data_a}, 32'h81);

    // 5: 5 data bits, 2 stop bits; good frame then second stop bit 0
    send(2, {8'b0, 2'b11, 5'b01001, 1'b0}, 8, 1'b0);
    chk("t5_cnt0",  nval_s, 32'd1);
    chk("t5_data0", {27'b0, data_s}, 32'h09);
    chk("t5_ferr0", {31'b0, ferr_s}, 32'd0);
    cycles(20);
    send(2, {8'b0, 1'b0, 1'b1, 5'b10110, 1'b0}, 8, 1'b0);
    rxd_s = 1'b1;
    chk("t5_cnt1",  nval_s, 32'd2);
    chk("t5_data1", {27'b0, data_s}, 32'h16);
    chk("t5_ferr1", {31'b0, ferr_s}, 32'd1);
    chk("t5_brk1",  {31'b0, brk_s},  32'd0);
    chk("t5_perr1", {31'b0, perr_s}, 32'd0);
    cycles(30);
    chk("t5_idle_busy", {31'b0, busy_s}, 32'd0);

    // 6a: reset during data bit 3 of 0x5A
    send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 4, 1'b0);
    rxd_a = 1'b1;
    cycles(8);
    chk("t6_busy_pre", {31'b0, busy_a}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_data", {24'b0, data_a}, 32'd0);
    chk("t6_rst_ferr", {31'b0, ferr_a}, 32'd0);
    chk("t6_rst_brk",  {31'b0, brk_a},  32'd0);
    chk("t6_rst_busy", {31'b0, busy_a}, 32'd0);
    chk("t6_rst_valid", {31'b0, valid_a}, 32'd0);
    cycles(3);
    resetn = 1'b1;
    cycles(30);
    chk("t6_rst_cnt", nval_a, 32'd4);
    send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 1'b0);
    chk("t6_cnt",  nval_a, 32'd5);
    chk("t6_data", {24'b0, data_a}, 32'h5A);
    chk("t6_ferr", {31'b0, ferr_a}, 32'd0);
    cycles(20);

    // 6b: drop enable mid-frame
    send(0, {6'b0, 1'b1, 8'h33, 1'b0}, 3, 1'b0);
    chk("t6_en_busy_pre", {31'b0, busy_a}, 32'd1);
    en_a = 1'b0;
    cycles(1);
    chk("t6_en_busy", {31'b0, busy_a}, 32'd0);
    rxd_a = 1'b1;
    cycles(5);
    en_a = 1'b1;
    cycles(60);
    chk("t6_en_cnt",  nval_a, 32'd5);
    chk("t6_en_data", {24'b0, data_a}, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
